// File: rtl/fmap_window_reader_pkg.sv
// Shared defaults, FSM encoding and pipe slot layout for the feature-map window reader.
// Optional feature macro: FMAP_WINDOW_READER_ZERO_PAD_EN ("same" padding scan).
package fmap_window_reader_pkg;

  localparam int FWR_DATA_WIDTH      = 16;
  localparam int FWR_POOL_ADDR_WIDTH = 10;
  localparam int FWR_MAP_W           = 12;
  localparam int FWR_MAP_H           = 12;
  localparam int FWR_KSIZE           = 5;
  localparam int FWR_RD_LATENCY      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // One read slot travelling alongside the RAM data.
  typedef struct packed {
    logic valid;
    logic win_last;
    logic map_last;
    logic zero;
  } slot_t;

  // Number of window origins along one map dimension.
  function automatic int out_dim(input int map_dim, input int ksize);
`ifdef FMAP_WINDOW_READER_ZERO_PAD_EN
    return map_dim + 0 * ksize;
`else
    return map_dim - ksize + 1;
`endif
  endfunction

  // Border width added on each side of the map.
  function automatic int pad_of(input int ksize);
`ifdef FMAP_WINDOW_READER_ZERO_PAD_EN
    return ksize / 2;
`else
    return 0 * ksize;
`endif
  endfunction

endpackage

// File: rtl/fmap_window_reader_win_addr_gen.sv
// Window counters with incremental (adder-only) RAM address and last/pad slot flags.
// With FMAP_WINDOW_READER_ZERO_PAD_EN the scan is centred and out-of-map slots are flagged.
module fmap_window_reader_win_addr_gen
  import fmap_window_reader_pkg::*;
#(
  parameter int POOL_ADDR_WIDTH = FWR_POOL_ADDR_WIDTH,
  parameter int MAP_W           = FWR_MAP_W,
  parameter int MAP_H           = FWR_MAP_H,
  parameter int KSIZE           = FWR_KSIZE
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       step,
  output logic [POOL_ADDR_WIDTH-1:0] addr,
  output logic                       slot_pad,
  output logic                       slot_win_last,
  output logic                       slot_map_last
);

  localparam int OUT_W = out_dim(MAP_W, KSIZE);
  localparam int OUT_H = out_dim(MAP_H, KSIZE);
  localparam int P     = pad_of(KSIZE);
  localparam int CW    = $clog2((MAP_W > MAP_H ? MAP_W : MAP_H) + 1);
`ifdef FMAP_WINDOW_READER_ZERO_PAD_EN
  localparam int SW    = POOL_ADDR_WIDTH + 2;
`else
  localparam int SW    = POOL_ADDR_WIDTH;
`endif

  localparam logic [CW-1:0] K_MAX   = CW'(KSIZE - 1);
  localparam logic [CW-1:0] OW_MAX  = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OH_MAX  = CW'(OUT_H - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [SW-1:0] A_ONE   = SW'(1);
  localparam logic [SW-1:0] ROW_STP = SW'(MAP_W);
  // Address of the top-left window corner; negative (two's complement) when padding.
  localparam logic [SW-1:0] BASE0   = SW'(0 - (P * MAP_W + P));

  logic [CW-1:0] kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic [SW-1:0] oy_base_q, oy_base_d, win_base_q, win_base_d;
  logic [SW-1:0] row_base_q, row_base_d, addr_q, addr_d;

  // Advance kx, then ky, then ox, then oy; bases move by +1, +MAP_W or reload.
  always_comb begin
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    oy_base_d  = oy_base_q;
    win_base_d = win_base_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (clear) begin
      kx_d       = '0;
      ky_d       = '0;
      ox_d       = '0;
      oy_d       = '0;
      oy_base_d  = BASE0;
      win_base_d = BASE0;
      row_base_d = BASE0;
      addr_d     = BASE0;
    end else if (step) begin
      if (kx_q != K_MAX) begin
        kx_d   = kx_q + C_ONE;
        addr_d = addr_q + A_ONE;
      end else begin
        kx_d = '0;
        if (ky_q != K_MAX) begin
          ky_d       = ky_q + C_ONE;
          row_base_d = row_base_q + ROW_STP;
          addr_d     = row_base_q + ROW_STP;
        end else begin
          ky_d = '0;
          if (ox_q != OW_MAX) begin
            ox_d       = ox_q + C_ONE;
            win_base_d = win_base_q + A_ONE;
            row_base_d = win_base_q + A_ONE;
            addr_d     = win_base_q + A_ONE;
          end else begin
            ox_d = '0;
            if (oy_q != OH_MAX) begin
              oy_d       = oy_q + C_ONE;
              oy_base_d  = oy_base_q + ROW_STP;
              win_base_d = oy_base_q + ROW_STP;
              row_base_d = oy_base_q + ROW_STP;
              addr_d     = oy_base_q + ROW_STP;
            end else begin
              oy_d       = '0;
              oy_base_d  = BASE0;
              win_base_d = BASE0;
              row_base_d = BASE0;
              addr_d     = BASE0;
            end
          end
        end
      end
    end
  end

  // Counter and address registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      oy_base_q  <= '0;
      win_base_q <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      oy_base_q  <= oy_base_d;
      win_base_q <= win_base_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  // Slot flags for the position currently held in the counters.
  always_comb begin
    slot_win_last = (kx_q == K_MAX) && (ky_q == K_MAX);
    slot_map_last = slot_win_last && (ox_q == OW_MAX) && (oy_q == OH_MAX);
  end

`ifdef FMAP_WINDOW_READER_ZERO_PAD_EN
  // A slot is padding when its map coordinate falls outside [0, MAP) on either axis.
  always_comb begin
    int px, py;
    px       = int'(ox_q) + int'(kx_q);
    py       = int'(oy_q) + int'(ky_q);
    slot_pad = (px < P) || (px >= MAP_W + P) || (py < P) || (py >= MAP_H + P);
    addr     = slot_pad ? '0 : addr_q[POOL_ADDR_WIDTH-1:0];
  end
`else
  // Valid scan: every slot is inside the map.
  always_comb begin
    slot_pad = 1'b0;
    addr     = addr_q;
  end
`endif

endmodule

// File: rtl/fmap_window_reader.sv
// Feature-map window reader: FSM, RAM port-B read issue and the read-latency flag pipe.
// Optional feature macro: FMAP_WINDOW_READER_ZERO_PAD_EN (zero-padded "same" scan).
// Stream handshake: pix_valid alone qualifies pix_out/win_last/map_last; there is no
// ready, so the consumer must take one pixel on every cycle pix_valid is high.
module fmap_window_reader
  import fmap_window_reader_pkg::*;
#(
  parameter int DATA_WIDTH      = FWR_DATA_WIDTH,
  parameter int POOL_ADDR_WIDTH = FWR_POOL_ADDR_WIDTH,
  parameter int MAP_W           = FWR_MAP_W,
  parameter int MAP_H           = FWR_MAP_H,
  parameter int KSIZE           = FWR_KSIZE,
  parameter int RD_LATENCY      = FWR_RD_LATENCY
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [POOL_ADDR_WIDTH-1:0] address_b_t,
  output logic                       rden_b,
  input  logic [DATA_WIDTH-1:0]      q_b,
  output logic [DATA_WIDTH-1:0]      pix_out,
  output logic                       pix_valid,
  output logic                       win_last,
  output logic                       map_last,
  output logic [1:0]                 dbg_state
);

  localparam int DW = $clog2(RD_LATENCY + 2);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(RD_LATENCY);
  localparam logic [DW-1:0] D_ONE     = DW'(1);

  state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic clear, step, slot_pad, slot_win_last, slot_map_last;
  slot_t new_slot, tail;
  slot_t pipe_q [RD_LATENCY];
  slot_t pipe_d [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pix_out_q, pix_out_d;
  logic pix_valid_q, pix_valid_d, win_last_q, win_last_d, map_last_q, map_last_d;

  fmap_window_reader_win_addr_gen #(
    .POOL_ADDR_WIDTH (POOL_ADDR_WIDTH),
    .MAP_W           (MAP_W),
    .MAP_H           (MAP_H),
    .KSIZE           (KSIZE)
  ) u_addr_gen (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .step          (step),
    .addr          (address_b_t),
    .slot_pad      (slot_pad),
    .slot_win_last (slot_win_last),
    .slot_map_last (slot_map_last)
  );

  // Next-state logic: one read slot per READ cycle, then drain the pipe before done.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clear   = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          clear   = 1'b1;
        end
      end
      ST_READ: begin
        step = 1'b1;
        if (slot_map_last) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_MAX) state_d = ST_FIN;
        else                      drain_d = drain_q + D_ONE;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and drain counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Slot issue and flag shift: the tail stage lines up with q_b.
  always_comb begin
    new_slot.valid    = (state_q == ST_READ);
    new_slot.win_last = (state_q == ST_READ) && slot_win_last;
    new_slot.map_last = (state_q == ST_READ) && slot_map_last;
    new_slot.zero     = (state_q == ST_READ) && slot_pad;
    pipe_d[0] = new_slot;
    for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    tail = pipe_q[RD_LATENCY-1];
  end

  // Flag pipe registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Output stage: capture RAM data with its flags; pix_out holds between pixels.
  always_comb begin
    pix_out_d   = pix_out_q;
    pix_valid_d = tail.valid;
    win_last_d  = tail.valid && tail.win_last;
    map_last_d  = tail.valid && tail.map_last;
    if (tail.valid) pix_out_d = tail.zero ? '0 : q_b;
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      map_last_q  <= 1'b0;
    end else begin
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      win_last_q  <= win_last_d;
      map_last_q  <= map_last_d;
    end
  end

  // Status decodes from the state register.
  always_comb begin
    rden_b    = (state_q == ST_READ) && !slot_pad;
    busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
    done      = (state_q == ST_FIN);
    pix_out   = pix_out_q;
    pix_valid = pix_valid_q;
    win_last  = win_last_q;
    map_last  = map_last_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_fmap_window_reader.sv
// Testbench for fmap_window_reader: 4x4 map, 3x3 window, 1-cycle RAM whose data = address.
module tb_fmap_window_reader;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int MW = 4;
  localparam int MH = 4;
  localparam int K  = 3;
  localparam int L  = 1;
`ifdef FMAP_WINDOW_READER_ZERO_PAD_EN
  localparam int P  = K / 2;
  localparam int OW = MW;
  localparam int OH = MH;
`else
  localparam int P  = 0;
  localparam int OW = MW - K + 1;
  localparam int OH = MH - K + 1;
`endif
  localparam int TOTAL = OW * OH * K * K;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rden_b, pix_valid, win_last, map_last;
  logic [AW-1:0] address_b_t;
  logic [DW-1:0] q_b = '0;
  logic [DW-1:0] pix_out;
  logic [1:0]    dbg_state;

  fmap_window_reader #(
    .DATA_WIDTH      (DW),
    .POOL_ADDR_WIDTH (AW),
    .MAP_W           (MW),
    .MAP_H           (MH),
    .KSIZE           (K),
    .RD_LATENCY      (L)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .address_b_t (address_b_t),
    .rden_b      (rden_b),
    .q_b         (q_b),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .win_last    (win_last),
    .map_last    (map_last),
    .dbg_state   (dbg_state)
  );

  // Clock, cycle counter and RAM model (data = address, one cycle latency).
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (rden_b) q_b <= DW'(address_b_t);

  // Scoreboard state.
  logic [AW-1:0] exp_addr_q[$];
  logic [DW+1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pix_count, first_pix_cyc, last_pix_cyc, done_cyc, done_count, rd_count, start_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference scan: window order oy, ox, ky, kx; padded positions read nothing and yield 0.
  task automatic push_scan();
    int x, y, a;
    logic wl, ml;
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            x  = ox + kx - P;
            y  = oy + ky - P;
            wl = (kx == K-1) && (ky == K-1);
            ml = wl && (ox == OW-1) && (oy == OH-1);
            if (x >= 0 && x < MW && y >= 0 && y < MH) begin
              a = y * MW + x;
              exp_addr_q.push_back(AW'(a));
            end else begin
              a = 0;
            end
            exp_q.push_back({ml, wl, DW'(a)});
          end
  endtask

  task automatic clear_stats();
    pix_count = 0; first_pix_cyc = -1; last_pix_cyc = -1;
    done_cyc = -1; done_count = 0; rd_count = 0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Monitor: pops expected reads/pixels as the DUT produces them.
  always @(negedge clock) begin
    if (!reset) begin
      if (rden_b) begin
        rd_count++;
        if (exp_addr_q.size() == 0) check("rd_unexpected", rden_b, 0);
        else check("rd_addr", address_b_t, exp_addr_q.pop_front());
      end
      if (pix_valid) begin
        if (pix_count == 0) first_pix_cyc = cyc;
        last_pix_cyc = cyc;
        pix_count++;
        if (exp_q.size() == 0) check("pix_unexpected", pix_valid, 0);
        else check("pix_ml_wl_data", {map_last, win_last, pix_out}, exp_q.pop_front());
        check("busy_on_pix", busy, 1);
      end else begin
        check("flags_idle", {win_last, map_last}, 0);
      end
      if (done) check("busy_at_done", busy, 0);
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // Full scan with optional ignored start re-pulse, then timing/count checks.
  task automatic run_scan(input bit repulse);
    clear_stats();
    push_scan();
    pulse_start();
    if (repulse) begin
      repeat (3) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    for (int i = 0; i < 2000 && done_count == 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    check("done_count", done_count, 1);
    check("pix_count", pix_count, TOTAL);
    check("first_pix_latency", first_pix_cyc, start_cyc + 3);
    check("pix_contiguous", last_pix_cyc, first_pix_cyc + TOTAL - 1);
    check("done_after_map_last", done_cyc, last_pix_cyc + 1);
    check("pix_q_empty", exp_q.size(), 0);
    check("addr_q_empty", exp_addr_q.size(), 0);
  endtask

  initial begin
    clear_stats();
    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_rden", rden_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_flags", {win_last, map_last}, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_addr", address_b_t, 0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("idle_no_rd", rd_count, 0);
    check("idle_no_done", done_count, 0);

    // Plain scan, scan with ignored start, and restart after done.
    run_scan(1'b0);
    run_scan(1'b1);
    run_scan(1'b0);

    // Reset at the 10th read: abort, no done, then a clean scan.
    clear_stats();
    push_scan();
    pulse_start();
    for (int i = 0; i < 200 && rd_count < 10; i++) @(posedge clock);
    check("rst_reached_10th", rd_count, 10);
    #1 reset = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clock);
    check("midrst_rden", rden_b, 0);
    check("midrst_pix_valid", pix_valid, 0);
    check("midrst_busy", busy, 0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("midrst_no_done", done_count, 0);
    check("midrst_idle_no_pix", pix_valid, 0);
    run_scan(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
